// File: rtl/uart_pkg.sv
// Shared types and constants for the board UART.
// Used by the TX core, RX core and board top.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser on an already synchronised line;
// valid pulses one cycle after a good stop sample.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 valid_q, valid_n;

  // State, sample counters, shift register and valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      valid_q <= valid_n;
    end
  end

  // Mid-bit sampling; a high line at mid-start is a glitch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    valid_n = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (!rxd) state_n = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_n   = '0;
          state_n = rxd ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_n   = '0;
          shift_n = {rxd, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) state_n = RX_STOP;
          else bit_n = bit_q + 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_n   = '0;
          valid_n = rxd;
          state_n = RX_CLEANUP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RX_CLEANUP: begin
        if (rxd) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign data  = shift_q;
  assign valid = valid_q;

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: start pulse latches a byte, done
// pulses on the edge the stop bit completes.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 line_q, line_n;

  // State, counters and the registered line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      line_q  <= line_n;
    end
  end

  // Next state; line level is computed alongside so it
  // changes on the same edge as the state.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    line_n  = line_q;
    done    = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        line_n = 1'b1;
        cnt_n  = '0;
        bit_n  = '0;
        if (start) begin
          shift_n = data;
          line_n  = 1'b0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == LAST) begin
          cnt_n   = '0;
          line_n  = shift_q[0];
          state_n = TX_DATA;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_n = '0;
          if (bit_q == LAST_BIT) begin
            line_n  = 1'b1;
            state_n = TX_STOP;
          end else begin
            bit_n   = bit_q + 1'b1;
            shift_n = {1'b0, shift_q[DATA_BITS-1:1]};
            line_n  = shift_q[1];
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_n   = '0;
          done    = 1'b1;
          state_n = TX_IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  assign txd  = line_q;
  assign busy = (state_q != TX_IDLE);

endmodule

// File: rtl/uart_board_top.sv
// Board wrapper: button sends an incrementing byte,
// received bytes go to the LEDs.
module uart_board_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic                 clk_100mhz,
  input  logic                 btn_reset,
  input  logic                 btn_tx_trigger,
  input  logic                 uart_rxd_in,
  output logic                 uart_txd_out,
  output logic [DATA_BITS-1:0] leds,
  output logic                 led_tx_active,
  output logic                 led_rx_data_avail
);

  logic                 btn_s1, btn_s2, btn_prev;
  logic                 tx_start;
  logic                 rxd_s1, rxd_s2;
  logic [DATA_BITS-1:0] data_to_transmit;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_valid;
  logic                 tx_done;
  logic [DATA_BITS-1:0] leds_q;
  logic                 avail_q;

  // Two-flop synchronisers; the RX line idles high.
  always_ff @(posedge clk_100mhz) begin
    if (btn_reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      btn_s1 <= btn_tx_trigger;
      btn_s2 <= btn_s1;
      rxd_s1 <= uart_rxd_in;
      rxd_s2 <= rxd_s1;
    end
  end

  // Registered rising-edge detect gives a one-cycle start.
  always_ff @(posedge clk_100mhz) begin
    if (btn_reset) begin
      btn_prev <= 1'b0;
      tx_start <= 1'b0;
    end else begin
      btn_prev <= btn_s2;
      tx_start <= btn_s2 & ~btn_prev;
    end
  end

  // Next byte to send advances as each frame finishes.
  always_ff @(posedge clk_100mhz) begin
    if (btn_reset) data_to_transmit <= '0;
    else if (tx_done) data_to_transmit <= data_to_transmit + 1'b1;
  end

  // LEDs hold the last good byte and a sticky flag.
  always_ff @(posedge clk_100mhz) begin
    if (btn_reset) begin
      leds_q  <= '0;
      avail_q <= 1'b0;
    end else if (rx_valid) begin
      leds_q  <= rx_byte;
      avail_q <= 1'b1;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk_100mhz),
    .rst  (btn_reset),
    .start(tx_start),
    .data (data_to_transmit),
    .txd  (uart_txd_out),
    .busy (led_tx_active),
    .done (tx_done)
  );

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk  (clk_100mhz),
    .rst  (btn_reset),
    .rxd  (rxd_s2),
    .data (rx_byte),
    .valid(rx_valid)
  );

  assign leds              = leds_q;
  assign led_rx_data_avail = avail_q;

endmodule

// File: tb/tb_uart_board_top.sv
// Directed bench for uart_board_top at a short bit
// period: TX frames, RX bytes, errors, wrap and reset.
module tb_uart_board_top;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       btn_reset;
  logic       btn_tx_trigger;
  logic       uart_rxd_in;
  logic       uart_txd_out;
  logic [7:0] leds;
  logic       led_tx_active;
  logic       led_rx_data_avail;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_board_top #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk_100mhz       (clk),
    .btn_reset        (btn_reset),
    .btn_tx_trigger   (btn_tx_trigger),
    .uart_rxd_in      (uart_rxd_in),
    .uart_txd_out     (uart_txd_out),
    .leds             (leds),
    .led_tx_active    (led_tx_active),
    .led_rx_data_avail(led_rx_data_avail)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic pulse_btn();
    btn_tx_trigger = 1'b1;
    step(1);
    btn_tx_trigger = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b,
                          input logic stop_bit);
    uart_rxd_in = 1'b0;
    step(C);
    for (int i = 0; i < 8; i++) begin
      uart_rxd_in = b[i];
      step(C);
    end
    uart_rxd_in = stop_bit;
    step(C);
    uart_rxd_in = 1'b1;
  endtask

  // Waits (bounded) for a start bit, then samples each
  // bit centre and checks the busy window edges.
  task automatic capture_tx(input logic [7:0] exp,
                            input string tag);
    logic [7:0] b;
    int k;
    k = 0;
    while (uart_txd_out !== 1'b0 && k < 30 * C) begin
      step(1);
      k++;
    end
    check({tag, "_start_edge"}, uart_txd_out, 0);
    check({tag, "_active"}, led_tx_active, 1);
    step(C / 2);
    check({tag, "_start_mid"}, uart_txd_out, 0);
    for (int i = 0; i < 8; i++) begin
      step(C);
      b[i] = uart_txd_out;
    end
    check({tag, "_data"}, b, exp);
    step(C);
    check({tag, "_stop"}, uart_txd_out, 1);
    step(C / 2 - 1);
    check({tag, "_active_last"}, led_tx_active, 1);
    step(1);
    check({tag, "_active_drop"}, led_tx_active, 0);
    check({tag, "_idle_line"}, uart_txd_out, 1);
  endtask

  initial begin
    logic seen_low;
    btn_reset      = 1'b1;
    btn_tx_trigger = 1'b0;
    uart_rxd_in    = 1'b1;
    step(4);
    check("rst_txd", uart_txd_out, 1);
    check("rst_leds", leds, 8'h00);
    check("rst_active", led_tx_active, 0);
    check("rst_avail", led_rx_data_avail, 0);
    btn_reset = 1'b0;
    step(3);

    btn_tx_trigger = 1'b1;
    step(1);
    btn_tx_trigger = 1'b0;
    step(2);
    check("lat_n2_high", uart_txd_out, 1);
    step(1);
    check("lat_n3_low", uart_txd_out, 0);
    capture_tx(8'h00, "frame00");

    fork
      drive_rx(8'h41, 1'b1);
      begin
        step(155);
        check("rxA_before_leds", leds, 8'h00);
        check("rxA_before_avail", led_rx_data_avail, 0);
        step(1);
        check("rxA_leds", leds, 8'h41);
        check("rxA_avail", led_rx_data_avail, 1);
      end
    join
    step(C);

    pulse_btn();
    capture_tx(8'h01, "frame01");
    pulse_btn();
    fork
      capture_tx(8'h02, "frame02");
      begin
        step(50);
        pulse_btn();
      end
    join
    seen_low = 1'b0;
    for (int i = 0; i < 15 * C; i++) begin
      step(1);
      if (uart_txd_out === 1'b0) seen_low = 1'b1;
    end
    check("busy_trigger_ignored", seen_low, 0);

    drive_rx(8'h5A, 1'b0);
    step(2 * C);
    check("ferr_leds", leds, 8'h41);
    check("ferr_avail", led_rx_data_avail, 1);

    uart_rxd_in = 1'b0;
    step(1);
    uart_rxd_in = 1'b1;
    step(12 * C);
    check("glitch_leds", leds, 8'h41);

    pulse_btn();
    fork
      capture_tx(8'h03, "sim_tx03");
      drive_rx(8'hC3, 1'b1);
    join
    step(4);
    check("sim_rx_leds", leds, 8'hC3);

    for (int v = 4; v < 256; v++) begin
      pulse_btn();
      capture_tx(8'(v), "seq");
    end
    pulse_btn();
    capture_tx(8'h00, "wrap00");

    pulse_btn();
    fork
      drive_rx(8'h99, 1'b1);
      begin
        step(60);
        check("pre_rst_active", led_tx_active, 1);
        btn_reset = 1'b1;
        step(1);
        check("midrst_txd", uart_txd_out, 1);
        check("midrst_leds", leds, 8'h00);
        check("midrst_active", led_tx_active, 0);
        check("midrst_avail", led_rx_data_avail, 0);
      end
    join
    step(2);
    btn_reset = 1'b0;
    step(3);
    pulse_btn();
    capture_tx(8'h00, "post_rst00");
    check("post_rst_leds", leds, 8'h00);
    check("post_rst_avail", led_rx_data_avail, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
